// File: rtl/uart_rx.sv
// UART receiver: start-edge detect, mid-bit sampling, LSB-first data, optional parity, stop check.
// Define UART_RX_SYNC_EN to insert a two-flop synchroniser ahead of the rx input register.
module uart_rx #(
  parameter int BITS         = 8,
  parameter int STOPBITS     = 1,
  parameter int PARITY       = 0,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic [BITS-1:0] data,
  output logic            data_valid,
  output logic            parity_err,
  output logic            frame_err,
  output logic            busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int BW   = $clog2(BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_cnt;
  logic [BITS-1:0] shift_reg;
  logic            par_bit;
  logic            stop_err;
  logic            need_high;
  logic            rx_q;
  logic            par_calc;
  logic            par_err_next;
  logic            stop_bad;

`ifdef UART_RX_SYNC_EN
  logic sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      rx_q  <= sync2;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_q <= 1'b1;
    else     rx_q <= rx;
  end
`endif

  always_comb begin
    par_calc     = (^shift_reg) ^ par_bit;
    par_err_next = 1'b0;
    if (PARITY == 1)      par_err_next = ~par_calc;
    else if (PARITY == 2) par_err_next = par_calc;
    stop_bad     = stop_err | ~rx_q;
  end

  // need_high keeps a stuck-low line from producing a stream of errored frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      stop_err   <= 1'b0;
      need_high  <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (rx_q) begin
            need_high <= 1'b0;
          end else if (!need_high) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (rx_q) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt       <= '0;
            shift_reg <= (shift_reg >> 1) | (BITS'(rx_q) << (BITS - 1));
            if (bit_cnt == BW'(BITS - 1)) begin
              bit_cnt  <= '0;
              stop_err <= 1'b0;
              state    <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PAR: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            par_bit <= rx_q;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt <= '0;
            if (bit_cnt == BW'(STOPBITS - 1)) begin
              data       <= shift_reg;
              parity_err <= par_err_next;
              frame_err  <= stop_bad;
              need_high  <= stop_bad;
              data_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              stop_err <= stop_bad;
              bit_cnt  <= bit_cnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (BITS=8, STOPBITS=1, even parity, 4 clocks per bit).
// A second instance built for odd parity shares the rx line.
module tb_uart_rx;

  localparam int CPB = 4;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 46;
`else
  localparam int LAT = 44;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       data_valid, parity_err, frame_err, busy;
  logic [7:0] odd_data;
  logic       odd_valid, odd_perr, odd_ferr, odd_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] q_data[$];
  logic       q_perr[$];
  logic       q_ferr[$];
  int         q_cyc[$];
  int         q_start[$];

  uart_rx #(.BITS(8), .STOPBITS(1), .PARITY(2), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  uart_rx #(.BITS(8), .STOPBITS(1), .PARITY(1), .CLKS_PER_BIT(CPB)) u_odd (
    .clk(clk), .rst(rst), .rx(rx), .data(odd_data), .data_valid(odd_valid),
    .parity_err(odd_perr), .frame_err(odd_ferr), .busy(odd_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid strobe on the falling edge, with its cycle stamp.
  always @(negedge clk) begin
    if (data_valid) begin
      q_data.push_back(data);
      q_perr.push_back(parity_err);
      q_ferr.push_back(frame_err);
      q_cyc.push_back(cyc);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearQueues();
    q_data.delete();
    q_perr.delete();
    q_ferr.delete();
    q_cyc.delete();
    q_start.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic p, input logic s);
    q_start.push_back(cyc);
    rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      waitCycles(CPB);
    end
    rx = p;
    waitCycles(CPB);
    rx = s;
    waitCycles(CPB);
  endtask

  function automatic logic [31:0] qd(input int i);
    return (q_data.size() > i) ? 32'(q_data[i]) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] qp(input int i);
    return (q_perr.size() > i) ? 32'(q_perr[i]) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] qf(input int i);
    return (q_ferr.size() > i) ? 32'(q_ferr[i]) : 32'hDEAD;
  endfunction
  function automatic logic [31:0] qlat(input int i);
    return (q_cyc.size() > i && q_start.size() > i) ? 32'(q_cyc[i] - q_start[i]) : 32'hDEAD;
  endfunction

  initial begin
    waitCycles(3);
    checkOutput("reset_data", 32'(data), 32'h0);
    checkOutput("reset_valid", 32'(data_valid), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_flags", 32'({parity_err, frame_err}), 32'h0);
    rst = 1'b0;
    waitCycles(4);

    // 1: clean frame, even parity bit 1
    clearQueues();
    applyStimulus(8'h57, 1'b1, 1'b1);
    waitCycles(8);
    checkOutput("t1_count", 32'(q_data.size()), 32'd1);
    checkOutput("t1_data", qd(0), 32'h57);
    checkOutput("t1_perr", qp(0), 32'h0);
    checkOutput("t1_ferr", qf(0), 32'h0);
    checkOutput("t1_latency", qlat(0), 32'(LAT));
    checkOutput("t1_busy_idle", 32'(busy), 32'h0);

    // 2: wrong even parity bit; correct for odd instance
    clearQueues();
    applyStimulus(8'h57, 1'b0, 1'b1);
    waitCycles(8);
    checkOutput("t2_count", 32'(q_data.size()), 32'd1);
    checkOutput("t2_data", qd(0), 32'h57);
    checkOutput("t2_perr", qp(0), 32'h1);
    checkOutput("t2_odd_perr", 32'(odd_perr), 32'h0);
    checkOutput("t2_odd_data", 32'(odd_data), 32'h57);

    // 3: stop bit low, line held low, then recovery
    clearQueues();
    applyStimulus(8'h57, 1'b1, 1'b0);
    waitCycles(100);
    checkOutput("t3_count_low", 32'(q_data.size()), 32'd1);
    checkOutput("t3_ferr", qf(0), 32'h1);
    checkOutput("t3_data", qd(0), 32'h57);
    checkOutput("t3_busy_low", 32'(busy), 32'h0);
    rx = 1'b1;
    waitCycles(4);
    applyStimulus(8'h57, 1'b1, 1'b1);
    waitCycles(8);
    checkOutput("t3_count_after", 32'(q_data.size()), 32'd2);
    checkOutput("t3_ferr_after", qf(1), 32'h0);

    // 4: one-cycle glitch
    clearQueues();
    rx = 1'b0;
    waitCycles(1);
    rx = 1'b1;
    waitCycles(1);
    checkOutput("t4_busy_high", 32'(busy), 32'h1);
    waitCycles(3);
    checkOutput("t4_busy_low", 32'(busy), 32'h0);
    waitCycles(50);
    checkOutput("t4_no_valid", 32'(q_data.size()), 32'd0);
    checkOutput("t4_flags", 32'({parity_err, frame_err}), 32'h0);
    checkOutput("t4_data_held", 32'(data), 32'h57);

    // 5: back-to-back frames with no idle gap
    clearQueues();
    applyStimulus(8'hA5, 1'b0, 1'b1);
    applyStimulus(8'h3C, 1'b0, 1'b1);
    waitCycles(8);
    checkOutput("t5_count", 32'(q_data.size()), 32'd2);
    checkOutput("t5_data0", qd(0), 32'hA5);
    checkOutput("t5_data1", qd(1), 32'h3C);
    checkOutput("t5_errs", qp(0) | qp(1) | qf(0) | qf(1), 32'h0);
    checkOutput("t5_lat0", qlat(0), 32'(LAT));
    checkOutput("t5_lat1", qlat(1), 32'(LAT));

    // 6: reset during data bit 4, then clean 0x81
    clearQueues();
    rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hC3 >> i);
      waitCycles(CPB);
    end
    rx = 1'b0;
    waitCycles(2);
    checkOutput("t6_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_data", 32'(data), 32'h0);
    checkOutput("t6_rst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(4);
    checkOutput("t6_no_valid", 32'(q_data.size()), 32'd0);
    applyStimulus(8'h81, 1'b0, 1'b1);
    waitCycles(8);
    checkOutput("t6_count", 32'(q_data.size()), 32'd1);
    checkOutput("t6_data", qd(0), 32'h81);
    checkOutput("t6_errs", qp(0) | qf(0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
